gpio_apb_master16: RTL



---
 rtl/gpio_apb_pkg16.sv | 27 ++
 rtl/apb_sync_fifo16.sv | 68 ++++++
 rtl/gpio_apb_master16.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gpio_apb_pkg16.sv
// Shared types and defaults for the GPIO APB initiator.
//   DefAddrW / DefDataW : default APB address / data widths
//   apb_state_e         : initiator FSM state
//   cmd_t / rsp_t       : command and response records at the default widths
package gpio_apb_pkg16;

    localparam int unsigned DefAddrW = 6;
    localparam int unsigned DefDataW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_state_e;

    typedef struct packed {
        logic                write;
        logic [DefAddrW-1:0] addr;
        logic [DefDataW-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic                write;
        logic [DefDataW-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/apb_sync_fifo16.sv
// Synchronous FIFO with full/empty/count.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write side; a push while full is taken only with a same-cycle pop
//   pop/rdata  : read side; rdata is the head, or wdata when empty (write-through)
//   full/empty : status; count : occupancy, width log2(DEPTH)+1
// Push and pop together on an empty FIFO hand wdata straight through and leave
// the FIFO empty, so a consumer can take an entry in the cycle it arrives.
module apb_sync_fifo16 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             pass_through;
    logic             do_push;
    logic             do_pop;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CntW'(DEPTH));
    assign count        = count_q;
    assign pass_through = empty && push && pop;
    assign do_push      = push && !pass_through && (!full || pop);
    assign do_pop       = pop && !empty;
    assign rdata        = empty ? wdata : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_apb_master16.sv
// APB (no pready/pslverr) initiator for the GPIO peripheral.
//   pclk16, n_p_reset16           : clock, asynchronous active-low reset
//   req_valid/ready/write/addr/wdata : command stream in
//   rsp_valid/ready/write/rdata   : response stream out (rdata is 0 for writes)
//   psel16, penable16, pwrite16, paddr16, pwdata16, prdata16 : APB port group
//   idle                          : both buffers empty and FSM idle
// A transfer is only started when the response buffer is guaranteed room for
// it, so ACCESS never has to stall.
module gpio_apb_master16
    import gpio_apb_pkg16::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned CMD_DEPTH = 2,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic              pclk16,
    input  logic              n_p_reset16,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              psel16,
    output logic              penable16,
    output logic              pwrite16,
    output logic [ADDR_W-1:0] paddr16,
    output logic [DATA_W-1:0] pwdata16,
    input  logic [DATA_W-1:0] prdata16,
    output logic              idle
);

    localparam int unsigned CmdW    = 1 + ADDR_W + DATA_W;
    localparam int unsigned RspW    = 1 + DATA_W;
    localparam int unsigned CmdCntW = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned RspCntW = $clog2(RSP_DEPTH) + 1;
    // Response count below which a transfer completing this cycle still leaves credit.
    localparam logic [RspCntW-1:0] RspLast = RspCntW'(RSP_DEPTH - 1);

    apb_state_e state_q, state_d;

    logic               cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [CmdCntW-1:0] cmd_count;
    logic [CmdW-1:0]    cmd_in, cmd_head;
    logic               cmd_avail;

    logic               rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [RspCntW-1:0] rsp_count;
    logic [RspW-1:0]    rsp_in, rsp_head;
    logic [DATA_W-1:0]  rd_capture;

    logic               pwrite_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic [DATA_W-1:0]  pwdata_q;
    logic               start;

    // Command buffer
    assign req_ready = !cmd_full;
    assign cmd_push  = req_valid && req_ready;
    assign cmd_in    = {req_write, req_addr, req_wdata};
    // An entry arriving this cycle counts, via the FIFO write-through.
    assign cmd_avail = !cmd_empty || cmd_push;

    apb_sync_fifo16 #(
        .WIDTH (CmdW),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (pclk16),
        .rst_n (n_p_reset16),
        .push  (cmd_push),
        .wdata (cmd_in),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    // Response buffer
    assign rd_capture = pwrite_q ? '0 : prdata16;
    assign rsp_in     = {pwrite_q, rd_capture};
    assign rsp_push   = (state_q == StAccess);
    assign rsp_pop    = rsp_valid && rsp_ready;
    assign rsp_valid  = !rsp_empty;
    assign rsp_write  = rsp_valid && rsp_head[DATA_W];
    assign rsp_rdata  = rsp_valid ? rsp_head[DATA_W-1:0] : '0;

    apb_sync_fifo16 #(
        .WIDTH (RspW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (pclk16),
        .rst_n (n_p_reset16),
        .push  (rsp_push),
        .wdata (rsp_in),
        .pop   (rsp_pop),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    // Credit: RSP_DEPTH - responses held - transfer in flight must stay positive.
    always_comb begin
        start = 1'b0;
        unique case (state_q)
            StIdle:   start = cmd_avail && !rsp_full;
            StAccess: start = cmd_avail && (rsp_count < RspLast);
            default:  start = 1'b0;
        endcase
    end

    assign cmd_pop = start;

    // FSM state register
    always_ff @(posedge pclk16 or negedge n_p_reset16) begin
        if (!n_p_reset16) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = start ? StSetup : StIdle;
            StSetup:  state_d = StAccess;
            StAccess: state_d = start ? StSetup : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        psel16    = 1'b0;
        penable16 = 1'b0;
        unique case (state_q)
            StSetup: psel16 = 1'b1;
            StAccess: begin
                psel16    = 1'b1;
                penable16 = 1'b1;
            end
            default: ;
        endcase
    end

    // Address/data are loaded only when a transfer starts and held otherwise.
    always_ff @(posedge pclk16 or negedge n_p_reset16) begin
        if (!n_p_reset16) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (cmd_pop) begin
            {pwrite_q, paddr_q, pwdata_q} <= cmd_head;
        end
    end

    assign pwrite16 = pwrite_q;
    assign paddr16  = paddr_q;
    assign pwdata16 = pwdata_q;
    assign idle     = (cmd_count == '0) && rsp_empty && (state_q == StIdle);

endmodule
